// File: rtl/voice_allocator.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : voice_allocator
// Description : Polyphonic voice scheduler: assigns note events to voice slots
//               (retrigger, then free slot, then steal oldest).
// Revision    : 1.0 - initial release
// ============================================================================
module voice_allocator #(
    parameter int VOICES = 4,
    parameter int NOTE_W = 7,
    parameter int VEL_W  = 7
) (
    input  logic                       inClk,
    input  logic                       inResetN,
    input  logic                       inEventValid,
    output logic                       outEventReady,
    input  logic                       inEventNoteOn,
    input  logic [NOTE_W-1:0]          inEventNote,
    input  logic [VEL_W-1:0]           inEventVelocity,
    input  logic                       inAllNotesOff,
    output logic [VOICES*NOTE_W-1:0]   outVoiceNote,
    output logic [VOICES*VEL_W-1:0]    outVoiceVelocity,
    output logic [VOICES-1:0]          outVoiceGate,
    output logic [VOICES-1:0]          outVoiceTrigger,
    output logic                       outStealPulse
);

    localparam int AGE_W = $clog2(VOICES);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_stateNext;
    logic [1:0]         r_rstSync;
    logic               w_rstN;
    logic               w_accept;

    logic [NOTE_W-1:0]  r_evNote;
    logic [VEL_W-1:0]   r_evVel;
    logic               r_evOn;

    logic               w_matchHit;
    logic [AGE_W-1:0]   w_matchIdx;
    logic               w_freeHit;
    logic [AGE_W-1:0]   w_freeIdx;
    logic [AGE_W-1:0]   w_oldestIdx;
    logic               r_matchHit;
    logic [AGE_W-1:0]   r_matchIdx;
    logic               r_freeHit;
    logic [AGE_W-1:0]   r_freeIdx;
    logic [AGE_W-1:0]   r_oldestIdx;
    logic [AGE_W-1:0]   w_target;
    logic [AGE_W-1:0]   w_targetAge;

    logic [NOTE_W-1:0]  r_voiceNote [VOICES];
    logic [VEL_W-1:0]   r_voiceVel  [VOICES];
    logic [AGE_W-1:0]   r_age       [VOICES];
    logic [VOICES-1:0]  r_gate;
    logic [VOICES-1:0]  r_trigger;
    logic               r_steal;

    // Reset asserts immediately but releases on a clock edge.
    always_ff @(posedge inClk or negedge inResetN) begin
        if (!inResetN) r_rstSync <= 2'b00;
        else           r_rstSync <= {r_rstSync[0], 1'b1};
    end
    assign w_rstN = r_rstSync[1];

    assign outEventReady = (r_state == ST_IDLE) && !inAllNotesOff;
    assign w_accept      = inEventValid && outEventReady;

    always_ff @(posedge inClk or negedge w_rstN) begin
        if (!w_rstN) r_state <= ST_IDLE;
        else         r_state <= w_stateNext;
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            ST_IDLE:   if (w_accept) w_stateNext = ST_SEARCH;
            ST_SEARCH: w_stateNext = ST_COMMIT;
            ST_COMMIT: w_stateNext = ST_IDLE;
            default:   w_stateNext = ST_IDLE;
        endcase
        if (inAllNotesOff) w_stateNext = ST_IDLE;
    end

    always_ff @(posedge inClk or negedge w_rstN) begin
        if (!w_rstN) begin
            r_evNote <= '0;
            r_evVel  <= '0;
            r_evOn   <= 1'b0;
        end else if (w_accept) begin
            r_evNote <= inEventNote;
            r_evVel  <= inEventVelocity;
            r_evOn   <= inEventNoteOn && (inEventVelocity != '0);
        end
    end

    // Descending scan so the lowest matching index wins.
    always_comb begin
        w_matchHit  = 1'b0;
        w_matchIdx  = '0;
        w_freeHit   = 1'b0;
        w_freeIdx   = '0;
        w_oldestIdx = '0;
        for (int i = VOICES - 1; i >= 0; i--) begin
            if (!r_gate[i]) begin
                w_freeHit = 1'b1;
                w_freeIdx = AGE_W'(i);
            end
            if (r_gate[i] && (r_voiceNote[i] == r_evNote)) begin
                w_matchHit = 1'b1;
                w_matchIdx = AGE_W'(i);
            end
            if (r_age[i] == AGE_W'(VOICES - 1)) w_oldestIdx = AGE_W'(i);
        end
    end

    always_ff @(posedge inClk or negedge w_rstN) begin
        if (!w_rstN) begin
            r_matchHit  <= 1'b0;
            r_matchIdx  <= '0;
            r_freeHit   <= 1'b0;
            r_freeIdx   <= '0;
            r_oldestIdx <= '0;
        end else if (r_state == ST_SEARCH) begin
            r_matchHit  <= w_matchHit;
            r_matchIdx  <= w_matchIdx;
            r_freeHit   <= w_freeHit;
            r_freeIdx   <= w_freeIdx;
            r_oldestIdx <= w_oldestIdx;
        end
    end

    assign w_target    = r_matchHit ? r_matchIdx : (r_freeHit ? r_freeIdx : r_oldestIdx);
    assign w_targetAge = r_age[w_target];

    always_ff @(posedge inClk or negedge w_rstN) begin
        if (!w_rstN) begin
            for (int i = 0; i < VOICES; i++) begin
                r_voiceNote[i] <= '0;
                r_voiceVel[i]  <= '0;
                r_age[i]       <= AGE_W'(i);
            end
            r_gate    <= '0;
            r_trigger <= '0;
            r_steal   <= 1'b0;
        end else begin
            r_trigger <= '0;
            r_steal   <= 1'b0;
            if (inAllNotesOff) begin
                r_gate <= '0;
            end else if (r_state == ST_COMMIT) begin
                if (r_evOn) begin
                    r_voiceNote[w_target] <= r_evNote;
                    r_voiceVel[w_target]  <= r_evVel;
                    r_gate[w_target]      <= 1'b1;
                    r_trigger[w_target]   <= 1'b1;
                    r_steal               <= !r_matchHit && !r_freeHit;
                    // Move target to youngest; voices younger than it age by one.
                    for (int i = 0; i < VOICES; i++) begin
                        if (AGE_W'(i) == w_target)
                            r_age[i] <= '0;
                        else if (r_age[i] < w_targetAge)
                            r_age[i] <= r_age[i] + AGE_W'(1);
                    end
                end else if (r_matchHit) begin
                    r_gate[r_matchIdx] <= 1'b0;
                end
            end
        end
    end

    for (genvar gi = 0; gi < VOICES; gi++) begin : g_pack
        assign outVoiceNote[gi*NOTE_W +: NOTE_W]    = r_voiceNote[gi];
        assign outVoiceVelocity[gi*VEL_W +: VEL_W]  = r_voiceVel[gi];
    end

    assign outVoiceGate    = r_gate;
    assign outVoiceTrigger = r_trigger;
    assign outStealPulse   = r_steal;

endmodule
`default_nettype wire

// File: tb/tb_voice_allocator.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_voice_allocator
// Description : Scoreboard bench for voice_allocator with directed note events.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_voice_allocator;

    localparam int VOICES = 4;
    localparam int NOTE_W = 7;
    localparam int VEL_W  = 7;

    logic                     inClk = 1'b0;
    logic                     inResetN;
    logic                     inEventValid;
    logic                     outEventReady;
    logic                     inEventNoteOn;
    logic [NOTE_W-1:0]        inEventNote;
    logic [VEL_W-1:0]         inEventVelocity;
    logic                     inAllNotesOff;
    logic [VOICES*NOTE_W-1:0] outVoiceNote;
    logic [VOICES*VEL_W-1:0]  outVoiceVelocity;
    logic [VOICES-1:0]        outVoiceGate;
    logic [VOICES-1:0]        outVoiceTrigger;
    logic                     outStealPulse;

    always #10 inClk = ~inClk;

    voice_allocator #(.VOICES(VOICES), .NOTE_W(NOTE_W), .VEL_W(VEL_W)) dut (
        .inClk            (inClk),
        .inResetN         (inResetN),
        .inEventValid     (inEventValid),
        .outEventReady    (outEventReady),
        .inEventNoteOn    (inEventNoteOn),
        .inEventNote      (inEventNote),
        .inEventVelocity  (inEventVelocity),
        .inAllNotesOff    (inAllNotesOff),
        .outVoiceNote     (outVoiceNote),
        .outVoiceVelocity (outVoiceVelocity),
        .outVoiceGate     (outVoiceGate),
        .outVoiceTrigger  (outVoiceTrigger),
        .outStealPulse    (outStealPulse)
    );

    typedef struct {
        int         id;
        logic [27:0] note;
        logic [27:0] vel;
        logic [3:0]  gate;
        logic [3:0]  trig;
        logic        steal;
    } exp_t;

    exp_t sbQ[$];
    int   assertions = 0;
    int   failures   = 0;
    int   evId       = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        assertions++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expectSnap(input int n0, input int n1, input int n2, input int n3,
                              input int v0, input int v1, input int v2, input int v3,
                              input logic [3:0] g, input logic [3:0] t, input logic s);
        exp_t e;
        e.id    = evId;
        evId++;
        e.note  = {7'(n3), 7'(n2), 7'(n1), 7'(n0)};
        e.vel   = {7'(v3), 7'(v2), 7'(v1), 7'(v0)};
        e.gate  = g;
        e.trig  = t;
        e.steal = s;
        sbQ.push_back(e);
    endtask

    // Monitor: an accepted event shows its result three negedges later.
    int cd       = 0;
    bit pulseChk = 1'b0;
    always @(negedge inClk) begin
        exp_t e;
        if (pulseChk) begin
            check("pulse_clear_trig", 32'(outVoiceTrigger), 32'd0);
            check("pulse_clear_steal", 32'(outStealPulse), 32'd0);
            pulseChk = 1'b0;
        end
        if (cd > 0) begin
            cd--;
            if (cd == 0) begin
                if (sbQ.size() == 0) begin
                    assertions++;
                    failures++;
                    $display("FAIL sb_underflow: got no expected entry, expected one queued");
                end else begin
                    e = sbQ.pop_front();
                    check($sformatf("ev%0d_note", e.id), 32'(outVoiceNote), 32'(e.note));
                    check($sformatf("ev%0d_vel", e.id), 32'(outVoiceVelocity), 32'(e.vel));
                    check($sformatf("ev%0d_gate", e.id), 32'(outVoiceGate), 32'(e.gate));
                    check($sformatf("ev%0d_trig", e.id), 32'(outVoiceTrigger), 32'(e.trig));
                    check($sformatf("ev%0d_steal", e.id), 32'(outStealPulse), 32'(e.steal));
                    pulseChk = 1'b1;
                end
            end
        end
        if (inResetN && inEventValid && outEventReady) cd = 3;
    end

    // Drives one event, scrambles the data while busy, and checks the ready pattern.
    task automatic sendEvent(input logic on, input int note, input int vel);
        int n;
        @(posedge inClk); #1;
        inEventValid    = 1'b1;
        inEventNoteOn   = on;
        inEventNote     = 7'(note);
        inEventVelocity = 7'(vel);
        n = 0;
        @(negedge inClk);
        while (!outEventReady && n < 20) begin
            @(negedge inClk);
            n++;
        end
        if (!outEventReady) begin
            assertions++;
            failures++;
            $display("FAIL accept_timeout: got ready=0, expected ready=1 within 20 cycles");
            inEventValid = 1'b0;
            return;
        end
        @(posedge inClk); #1;
        inEventNoteOn   = ~on;
        inEventNote     = ~7'(note);
        inEventVelocity = ~7'(vel);
        @(negedge inClk);
        check("ready_busy1", 32'(outEventReady), 32'd0);
        @(posedge inClk); #1;
        @(negedge inClk);
        check("ready_busy2", 32'(outEventReady), 32'd0);
        @(posedge inClk); #1;
        inEventValid = 1'b0;
        @(negedge inClk);
        check("ready_back", 32'(outEventReady), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        inResetN        = 1'b0;
        inEventValid    = 1'b0;
        inEventNoteOn   = 1'b0;
        inEventNote     = '0;
        inEventVelocity = '0;
        inAllNotesOff   = 1'b0;
        repeat (3) @(posedge inClk);
        #1 inResetN = 1'b1;
        repeat (3) @(posedge inClk);
        @(negedge inClk);
        check("rst_note", 32'(outVoiceNote), 32'd0);
        check("rst_vel", 32'(outVoiceVelocity), 32'd0);
        check("rst_gate", 32'(outVoiceGate), 32'd0);
        check("rst_trig", 32'(outVoiceTrigger), 32'd0);
        check("rst_steal", 32'(outStealPulse), 32'd0);
        check("rst_ready", 32'(outEventReady), 32'd1);

        // Fill all four voices, then steal the oldest.
        expectSnap(60, 0, 0, 0, 100, 0, 0, 0, 4'b0001, 4'b0001, 1'b0);
        sendEvent(1'b1, 60, 100);
        expectSnap(60, 62, 0, 0, 100, 80, 0, 0, 4'b0011, 4'b0010, 1'b0);
        sendEvent(1'b1, 62, 80);
        expectSnap(60, 62, 64, 0, 100, 80, 90, 0, 4'b0111, 4'b0100, 1'b0);
        sendEvent(1'b1, 64, 90);
        expectSnap(60, 62, 64, 65, 100, 80, 90, 70, 4'b1111, 4'b1000, 1'b0);
        sendEvent(1'b1, 65, 70);
        expectSnap(67, 62, 64, 65, 60, 80, 90, 70, 4'b1111, 4'b0001, 1'b1);
        sendEvent(1'b1, 67, 60);
        // Retrigger of a held note.
        expectSnap(67, 62, 64, 65, 60, 50, 90, 70, 4'b1111, 4'b0010, 1'b0);
        sendEvent(1'b1, 62, 50);
        // Note-off keeps pitch, then the freed slot is reused.
        expectSnap(67, 62, 64, 65, 60, 50, 90, 70, 4'b1011, 4'b0000, 1'b0);
        sendEvent(1'b0, 64, 33);
        expectSnap(67, 62, 70, 65, 60, 50, 40, 70, 4'b1111, 4'b0100, 1'b0);
        sendEvent(1'b1, 70, 40);
        expectSnap(67, 62, 70, 65, 60, 50, 40, 70, 4'b1111, 4'b0000, 1'b0);
        sendEvent(1'b0, 99, 0);
        // Steal again, then release that note with a zero-velocity note-on.
        expectSnap(67, 62, 70, 72, 60, 50, 40, 30, 4'b1111, 4'b1000, 1'b1);
        sendEvent(1'b1, 72, 30);
        expectSnap(67, 62, 70, 72, 60, 50, 40, 30, 4'b0111, 4'b0000, 1'b0);
        sendEvent(1'b1, 72, 0);

        // Panic while the event is in SEARCH: event dropped, all gates cleared.
        expectSnap(67, 62, 70, 72, 60, 50, 40, 30, 4'b0000, 4'b0000, 1'b0);
        @(posedge inClk); #1;
        inEventValid = 1'b1; inEventNoteOn = 1'b1; inEventNote = 7'd80; inEventVelocity = 7'd20;
        @(negedge inClk);
        check("panic_ready_pre", 32'(outEventReady), 32'd1);
        @(posedge inClk); #1;
        inEventValid  = 1'b0;
        inAllNotesOff = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge inClk);
            check($sformatf("panic_ready_low%0d", k), 32'(outEventReady), 32'd0);
        end
        @(posedge inClk); #1;
        inAllNotesOff = 1'b0;
        @(negedge inClk);
        check("panic_ready_back", 32'(outEventReady), 32'd1);

        expectSnap(60, 62, 70, 72, 10, 50, 40, 30, 4'b0001, 4'b0001, 1'b0);
        sendEvent(1'b1, 60, 10);

        // Valid held with constant data: accepted twice, ready 1,0,0,1,0,0,1.
        expectSnap(60, 62, 70, 72, 10, 11, 40, 30, 4'b0011, 4'b0010, 1'b0);
        expectSnap(60, 62, 70, 72, 10, 11, 40, 30, 4'b0011, 4'b0010, 1'b0);
        @(posedge inClk); #1;
        inEventValid = 1'b1; inEventNoteOn = 1'b1; inEventNote = 7'd62; inEventVelocity = 7'd11;
        for (int k = 0; k < 7; k++) begin
            @(negedge inClk);
            check($sformatf("b2b_ready%0d", k), 32'(outEventReady), 32'(k % 3 == 0));
            if (k == 3) begin
                @(posedge inClk); #1;
                inEventValid = 1'b0;
            end
        end

        // Asynchronous reset while the event is in COMMIT.
        expectSnap(0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 1'b0);
        @(posedge inClk); #1;
        inEventValid = 1'b1; inEventNoteOn = 1'b1; inEventNote = 7'd64; inEventVelocity = 7'd5;
        @(negedge inClk);
        check("rstmid_ready_pre", 32'(outEventReady), 32'd1);
        @(posedge inClk); #1;
        inEventValid = 1'b0;
        @(posedge inClk); #1;
        inResetN = 1'b0;
        #1;
        check("rstmid_note", 32'(outVoiceNote), 32'd0);
        check("rstmid_vel", 32'(outVoiceVelocity), 32'd0);
        check("rstmid_gate", 32'(outVoiceGate), 32'd0);
        check("rstmid_trig", 32'(outVoiceTrigger), 32'd0);
        repeat (4) @(posedge inClk);
        #1 inResetN = 1'b1;
        repeat (4) @(posedge inClk);

        expectSnap(50, 0, 0, 0, 1, 0, 0, 0, 4'b0001, 4'b0001, 1'b0);
        sendEvent(1'b1, 50, 1);

        repeat (5) @(negedge inClk);
        check("sb_drained", 32'(sbQ.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
`default_nettype wire
